// File: rtl/mips_pkg.sv
// Shared constants and types for the multi-cycle MIPS core: opcodes, functs,
// ALU operations, ALU source-B selects and the controller state encoding.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} aluop_t;

  typedef enum logic [1:0] {SRCB_B, SRCB_FOUR, SRCB_IMM, SRCB_IMM4} srcb_t;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC,
    S_ALUWB, S_ADDIEX, S_ADDIWB, S_BRANCH, S_JUMP, S_ERROR
  } state_t;

  function automatic logic rtype_legal(input logic [5:0] fn);
    return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) ||
           (fn == FN_OR)  || (fn == FN_SLT);
  endfunction

  function automatic aluop_t funct_to_aluop(input logic [5:0] fn);
    case (fn)
      FN_SUB:  return ALU_SUB;
      FN_AND:  return ALU_AND;
      FN_OR:   return ALU_OR;
      FN_SLT:  return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mc_control.sv
// Multi-cycle controller: sequences each instruction through its states and
// owns the registered memory request, write strobe and sticky illegal flag.
module mc_control
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       illegal,
  output logic       irwrite,
  output logic       pcinc,
  output logic       abwrite,
  output logic       aluoutwrite,
  output logic       mdrwrite,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       iord,
  output logic       alusrca,
  output logic       branch,
  output logic       jump,
  output logic       retire,
  output srcb_t      alusrcb,
  output aluop_t     aluop
);

  state_t state;
  logic   done;

  assign done = mem_req & mem_ready;

  // mem_req is computed for the state being entered, so it is already high in
  // the first cycle of FETCH/MEMRD/MEMWR except straight after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_FETCH;
      mem_req <= 1'b0;
      mem_we  <= 1'b0;
      illegal <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          if (done) begin
            state   <= S_DECODE;
            mem_req <= 1'b0;
          end else begin
            mem_req <= 1'b1;
          end
        end
        S_DECODE: begin
          case (opcode)
            OP_LW, OP_SW: state <= S_MEMADR;
            OP_BEQ:       state <= S_BRANCH;
            OP_ADDI:      state <= S_ADDIEX;
            OP_J:         state <= S_JUMP;
            OP_RTYPE: begin
              if (rtype_legal(funct)) begin
                state <= S_EXEC;
              end else begin
                state   <= S_ERROR;
                illegal <= 1'b1;
              end
            end
            default: begin
              state   <= S_ERROR;
              illegal <= 1'b1;
            end
          endcase
        end
        S_MEMADR: begin
          state   <= (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
          mem_req <= 1'b1;
          mem_we  <= (opcode == OP_SW);
        end
        S_MEMRD: begin
          if (done) begin
            state   <= S_MEMWB;
            mem_req <= 1'b0;
          end
        end
        S_MEMWR: begin
          if (done) begin
            state  <= S_FETCH;
            mem_we <= 1'b0;
          end
        end
        S_EXEC:   state <= S_ALUWB;
        S_ADDIEX: state <= S_ADDIWB;
        S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: begin
          state   <= S_FETCH;
          mem_req <= 1'b1;
        end
        S_ERROR: begin
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
          illegal <= 1'b1;
        end
        default: state <= S_ERROR;
      endcase
    end
  end

  always_comb begin
    irwrite     = 1'b0;
    pcinc       = 1'b0;
    abwrite     = 1'b0;
    aluoutwrite = 1'b0;
    mdrwrite    = 1'b0;
    regwrite    = 1'b0;
    regdst      = 1'b0;
    memtoreg    = 1'b0;
    iord        = 1'b0;
    alusrca     = 1'b0;
    branch      = 1'b0;
    jump        = 1'b0;
    retire      = 1'b0;
    alusrcb     = SRCB_B;
    aluop       = ALU_ADD;
    case (state)
      S_FETCH: begin
        irwrite = done;
        pcinc   = done;
        alusrcb = SRCB_FOUR;
      end
      S_DECODE: begin
        abwrite     = 1'b1;
        aluoutwrite = 1'b1;
        alusrcb     = SRCB_IMM4;
      end
      S_MEMADR, S_ADDIEX: begin
        aluoutwrite = 1'b1;
        alusrca     = 1'b1;
        alusrcb     = SRCB_IMM;
      end
      S_MEMRD: begin
        iord     = 1'b1;
        mdrwrite = done;
      end
      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
        retire   = 1'b1;
      end
      S_MEMWR: begin
        iord   = 1'b1;
        retire = done;
      end
      S_EXEC: begin
        aluoutwrite = 1'b1;
        alusrca     = 1'b1;
        aluop       = funct_to_aluop(funct);
      end
      S_ALUWB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
        retire   = 1'b1;
      end
      S_ADDIWB: begin
        regwrite = 1'b1;
        retire   = 1'b1;
      end
      S_BRANCH: begin
        branch = 1'b1;
        retire = 1'b1;
      end
      S_JUMP: begin
        jump   = 1'b1;
        retire = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_multicycle.sv
// Multi-cycle MIPS core on one shared request/ready memory port: datapath,
// register file and ALU, sequenced by mc_control.
module mips_multicycle
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  output logic             mem_req,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_ready,
  output logic [31:0]      pc,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);

  logic [31:0] ir, mdr, a, b, aluout;
  logic [31:0] rf [32];
  logic [31:0] signimm, srca, srcb, alu_y, wdata;
  logic [4:0]  rs, rt, rd, wreg;

  logic   irwrite, pcinc, abwrite, aluoutwrite, mdrwrite, regwrite;
  logic   regdst, memtoreg, iord, alusrca, branch, jump, retire;
  srcb_t  alusrcb;
  aluop_t aluop;

  mc_control u_control (
    .clk         (clk),
    .reset       (reset),
    .opcode      (ir[31:26]),
    .funct       (ir[5:0]),
    .mem_ready   (mem_ready),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .illegal     (illegal),
    .irwrite     (irwrite),
    .pcinc       (pcinc),
    .abwrite     (abwrite),
    .aluoutwrite (aluoutwrite),
    .mdrwrite    (mdrwrite),
    .regwrite    (regwrite),
    .regdst      (regdst),
    .memtoreg    (memtoreg),
    .iord        (iord),
    .alusrca     (alusrca),
    .branch      (branch),
    .jump        (jump),
    .retire      (retire),
    .alusrcb     (alusrcb),
    .aluop       (aluop)
  );

  assign rs        = ir[25:21];
  assign rt        = ir[20:16];
  assign rd        = ir[15:11];
  assign signimm   = {{16{ir[15]}}, ir[15:0]};
  assign wreg      = regdst ? rd : rt;
  assign wdata     = memtoreg ? mdr : aluout;
  assign mem_addr  = iord ? aluout : pc;
  assign mem_wdata = b;

  always_comb begin
    srca = alusrca ? a : pc;
    case (alusrcb)
      SRCB_FOUR: srcb = 32'd4;
      SRCB_IMM:  srcb = signimm;
      SRCB_IMM4: srcb = {signimm[29:0], 2'b00};
      default:   srcb = b;
    endcase
    case (aluop)
      ALU_SUB: alu_y = srca - srcb;
      ALU_AND: alu_y = srca & srcb;
      ALU_OR:  alu_y = srca | srcb;
      ALU_SLT: alu_y = {31'd0, $signed(srca) < $signed(srcb)};
      default: alu_y = srca + srcb;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc      <= RESET_PC;
      ir      <= '0;
      mdr     <= '0;
      a       <= '0;
      b       <= '0;
      aluout  <= '0;
      instret <= '0;
      for (int unsigned i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      if (irwrite) ir <= mem_rdata;
      if (mdrwrite) mdr <= mem_rdata;
      if (pcinc) begin
        pc <= alu_y;
      end else if (branch && (a == b)) begin
        pc <= aluout;
      end else if (jump) begin
        pc <= {pc[31:28], ir[25:0], 2'b00};
      end
      if (abwrite) begin
        a <= rf[rs];
        b <= rf[rt];
      end
      if (aluoutwrite) aluout <= alu_y;
      // $0 is never written, so it reads as zero without a read-side mux.
      if (regwrite && (wreg != 5'd0)) rf[wreg] <= wdata;
      if (retire) instret <= instret + CNT_W'(1);
    end
  end

endmodule

// File: doc/mips_multicycle.md
# mips_multicycle

Parametrised multi-cycle successor to the single-cycle MIPS core: one unified memory port with a request/ready handshake replaces separate instruction and data memories, and a controller FSM sequences each instruction over 3–5 states. It tolerates arbitrary memory wait states, traps illegal opcodes into a sticky halt, and counts retired instructions. It sits under `top` in place of the single-cycle `mips`, connected to one shared memory.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `CNT_W`, 32, width of the retired-instruction counter.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `mem_req`  out  1  memory transaction request.
- `mem_we`  out  1  1 = write, 0 = read; valid while `mem_req`=1.
- `mem_addr`  out  32  byte address; word-aligned.
- `mem_wdata`  out  32  store data; valid when `mem_req`=1 and `mem_we`=1.
- `mem_rdata`  in  32  read data; sampled in the cycle with `mem_req`=1 and `mem_ready`=1.
- `mem_ready`  in  1  completes the transaction; may be high combinationally in the same cycle as `mem_req`.
- `pc`  out  32  current PC register.
- `illegal`  out  1  sticky; set on an unsupported opcode or funct.
- `instret`  out  CNT_W  count of retired instructions.

## Operation
- ISA subset:
  - R-type `add`, `sub`, `and`, `or`, `slt`
  - `lw`, `sw`, `beq`, `addi`, `j`
  - Any other opcode, or any other funct with opcode 0, is illegal.
- Internal registers: IR, MDR, A, B, ALUOut, and a 32×32 register file.
  - `$0` always reads 0; writes to it are discarded.
- FSM states and transitions:
  - FETCH: `mem_req`=1, `mem_we`=0, `mem_addr`=`pc`. Stays in FETCH until `mem_ready`. On completion: IR←`mem_rdata`, `pc`←`pc`+4, go to DECODE.
  - DECODE: A←rf[rs], B←rf[rt], ALUOut←`pc`+(signimm<<2). Next state:
    - `lw`/`sw` → MEMADR
    - R-type → EXEC
    - `beq` → BRANCH
    - `addi` → ADDIEX
    - `j` → JUMP
    - anything else → ERROR
  - MEMADR: ALUOut←A+signimm. Next: MEMRD for `lw`, MEMWR for `sw`.
  - MEMRD: read request at ALUOut; waits for `mem_ready`; MDR←`mem_rdata`; → MEMWB.
  - MEMWB: rf[rt]←MDR; retire; → FETCH.
  - MEMWR: write request, `mem_addr`=ALUOut, `mem_wdata`=B; waits for `mem_ready`; retire; → FETCH.
  - EXEC: ALUOut←A op B (op from funct); → ALUWB.
  - ALUWB: rf[rd]←ALUOut; retire; → FETCH.
  - ADDIEX: ALUOut←A+signimm; → ADDIWB.
  - ADDIWB: rf[rt]←ALUOut; retire; → FETCH.
  - BRANCH: if A==B then `pc`←ALUOut; retire; → FETCH.
  - JUMP: `pc`←{`pc`[31:28], IR[25:0], 2'b00}; retire; → FETCH.
  - ERROR: `illegal`=1, `mem_req`=0. Absorbing; only reset exits. The illegal instruction does not retire.
- Arithmetic:
  - 32-bit wrap-around on all adds and subtracts; no overflow trap.
  - `slt` is a signed compare.
  - signimm is IR[15:0] sign-extended.
- `instret` increments by 1 in each retire state and wraps modulo 2^CNT_W.

## Timing
- Reset (asynchronous assert, synchronous release) drives:
  - `pc`=RESET_PC, state=FETCH
  - `mem_req`=0, `mem_we`=0, `illegal`=0, `instret`=0
  - IR, MDR, A, B and ALUOut cleared to 0
  - register file cleared to 0
- `mem_req`=0 in the first cycle after reset release; FETCH asserts it from the next cycle.
- Handshake:
  - Once asserted, `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` hold stable until the cycle in which `mem_ready`=1.
  - `mem_req` deasserts in the following cycle unless the next state also requests.
- Cycles per instruction, zero-wait memory: `lw` 5, `sw` 4, R-type 4, `addi` 4, `beq` 3, `j` 3. Each memory wait cycle adds 1.
- `mem_ready` outside a request is ignored.
- Reset asserted mid-transaction drops `mem_req` immediately (asynchronously) and abandons the transaction.
- A register-file write in a writeback state is visible to the next instruction's DECODE.

## Structure
- `mips_pkg` holds:
  - the opcode constants (0x00, 0x23, 0x2B, 0x04, 0x08, 0x02)
  - the funct constants (0x20, 0x22, 0x24, 0x25, 0x2A)
  - the ALU-op enum
  - the state enum typedef
- One sub-module, `mc_control`: the FSM, producing mux selects, register enables, the ALU op, the memory request, the retire pulse and `illegal`.
- The datapath, register file and ALU live in the top module.

## Test plan
- Reset release with `RESET_PC`=0x100 → first request has `mem_addr`=0x100, `mem_we`=0; `pc`=0x104 after fetch completes.
- Program `addi $1,$0,5`; `addi $2,$0,-3`; `add $3,$1,$2`; `slt $4,$2,$1`; `sw $3,0x40($0)` → write request with addr 0x40, data 2; `instret`=5; $4=1.
- `lw $5,0x40($0)` with 3 wait cycles on the read → 8 cycles total, $5=2, `mem_req` held stable throughout.
- `beq` taken at 0x20 with offset 3 → next fetch at 0x30. Not taken → next fetch at 0x24. `j 0x40` → next fetch at 0x100.
- Opcode 0x3F → ERROR state; `illegal`=1, `mem_req` stays 0, `instret` unchanged; reset clears it.
- `addi $0,$0,7` then `add $6,$0,$0` → $6=0. Reset asserted during a pending write → `mem_req`=0 immediately and the write never completes.
